matrix_add_feeder: RTL and testbench
====================================

MATRIX_ADD_FEEDER -- requirements
Module: matrix_add_feeder

Interface
REQ-001 SHALL have parameter N_OFFSET, default 0: opcode base of the downstream add engine (NEXT = N_OFFSET+0, RESET = N_OFFSET+2).
REQ-002 SHALL have parameter MAX_COUNT_W, default 16: width of the element count.
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port go  input  1  one-cycle job-start request.
REQ-006 SHALL have ports base_a, base_b  input  32 each  byte addresses of matrices A and B, sampled on accepted go.
REQ-007 SHALL have port count  input  MAX_COUNT_W  number of element pairs, sampled on accepted go.
REQ-008 SHALL have ports busy and job_done  output  1 each  job active / one-cycle completion pulse.
REQ-009 SHALL have port issued  output  MAX_COUNT_W  number of pairs delivered in the current or last job.
REQ-010 SHALL have Avalon-MM read-master ports: avm_address (output, 32), avm_read (output, 1), avm_waitrequest (input, 1), avm_readdata (input, 32), avm_readdatavalid (input, 1).
REQ-011 SHALL have downstream ports: add_start (output, 1), add_n (output, 8), add_dataa (output, 32), add_datab (output, 32), add_done (input, 1).

Function
REQ-012 SHALL implement the states IDLE, CLR, RD_A, WAIT_A, RD_B, WAIT_B, ISSUE, FIN.
REQ-013 IDLE with go=1: SHALL latch base_a, base_b and count, clear issued, and go to CLR; go while not IDLE SHALL be ignored.
REQ-014 CLR: SHALL drive add_start=1 and add_n=N_OFFSET+2 until add_done=1 is seen in the same cycle; then go to RD_A if count!=0, else to FIN.
REQ-015 RD_A: SHALL drive avm_read=1 with avm_address=ptr_a and hold both stable while avm_waitrequest=1; when avm_waitrequest=0, go to WAIT_A.
REQ-016 WAIT_A: on avm_readdatavalid=1, SHALL capture avm_readdata into add_dataa and go to RD_B; RD_B/WAIT_B SHALL do the same with ptr_b and add_datab, then go to ISSUE.
REQ-017 Only one read SHALL be outstanding at any time; avm_readdatavalid outside WAIT_A/WAIT_B SHALL be ignored.
REQ-018 ISSUE: SHALL drive add_start=1 and add_n=N_OFFSET+0 with add_dataa/add_datab held; the cycle add_done=1 SHALL increment issued and advance ptr_a and ptr_b by 4 each (modulo 2^32 wrap).
REQ-019 After ISSUE completes: SHALL go to RD_A if issued+1 < count, else to FIN.
REQ-020 FIN: SHALL pulse job_done=1 for exactly one cycle and return to IDLE.
REQ-021 busy SHALL be 1 in every state except IDLE.
REQ-022 add_start and avm_read SHALL be 0 outside CLR/ISSUE and RD_A/RD_B respectively.
REQ-023 Minimum latency per pair with waitrequest=0 and 1-cycle readdatavalid SHALL be 5 cycles (RD_A, WAIT_A, RD_B, WAIT_B, ISSUE).
REQ-024 count=0 SHALL perform CLR only, then FIN, with no memory reads.

Reset
REQ-025 Asserting reset, including mid-job, SHALL immediately force IDLE with all outputs 0 (busy, job_done, issued, avm_address, avm_read, add_start, add_n, add_dataa, add_datab), regardless of any outstanding read.
REQ-026 A readdatavalid arriving after reset deassertion for a read aborted by reset SHALL be ignored.

Structure
REQ-027 State encodings, opcode offsets (NEXT=0, GET=1, RESET=2) and the word stride constant (4) SHALL live in a shared package used by both matrix_add_feeder and the add engine.
REQ-028 SHALL be a single module with no sub-modules; it connects directly to the add engine's dataa/datab/start/n/done ports.

Verification
REQ-029 go with base_a=0x100, base_b=0x200, count=3, zero-wait memory -> reads at 0x100,0x200,0x104,0x204,0x108,0x208; three NEXT issues; issued=3; job_done exactly once.
REQ-030 count=0 -> one RESET issue (add_n=N_OFFSET+2), no avm_read, job_done 2 cycles after go.
REQ-031 avm_waitrequest held high for 4 cycles on the first read -> avm_address/avm_read stable throughout; data order unchanged.
REQ-032 base_a=0xFFFFFFFC, count=2 -> second A read at 0x00000000.
REQ-033 reset asserted in WAIT_B of pair 2 -> all outputs 0 at once; late readdatavalid ignored; subsequent go runs from scratch.
REQ-034 go pulsed while busy -> ignored; latched count/bases unchanged; single job_done.

Source files
------------

// File: rtl/matrix_add_feeder_pkg.sv
// Shared definitions for the matrix feeder and the downstream add engine:
// state encoding, engine opcode offsets and the element stride.
package matrix_add_feeder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLR    = 3'd1,
    ST_RD_A   = 3'd2,
    ST_WAIT_A = 3'd3,
    ST_RD_B   = 3'd4,
    ST_WAIT_B = 3'd5,
    ST_ISSUE  = 3'd6,
    ST_FIN    = 3'd7
  } feeder_state_e;

  localparam int OP_NEXT  = 0;
  localparam int OP_GET   = 1;
  localparam int OP_RESET = 2;

  localparam logic [31:0] WORD_STRIDE = 32'd4;

  function automatic logic [7:0] opcode(input int base, input int op);
    return 8'(base + op);
  endfunction

endpackage

// File: rtl/matrix_add_feeder.sv
// Streams element pairs of two matrices from an Avalon-MM read master into
// the add engine: one RESET command per job, then one NEXT command per pair.
module matrix_add_feeder
  import matrix_add_feeder_pkg::*;
#(
  parameter int N_OFFSET    = 0,
  parameter int MAX_COUNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   go,
  input  logic [31:0]            base_a,
  input  logic [31:0]            base_b,
  input  logic [MAX_COUNT_W-1:0] count,
  output logic                   busy,
  output logic                   job_done,
  output logic [MAX_COUNT_W-1:0] issued,
  output logic [31:0]            avm_address,
  output logic                   avm_read,
  input  logic                   avm_waitrequest,
  input  logic [31:0]            avm_readdata,
  input  logic                   avm_readdatavalid,
  output logic                   add_start,
  output logic [7:0]             add_n,
  output logic [31:0]            add_dataa,
  output logic [31:0]            add_datab,
  input  logic                   add_done
);

  localparam logic [7:0] N_NEXT  = opcode(N_OFFSET, OP_NEXT);
  localparam logic [7:0] N_RESET = opcode(N_OFFSET, OP_RESET);

  feeder_state_e          state_q, state_d;
  logic [31:0]            ptrA_q, ptrA_d;
  logic [31:0]            ptrB_q, ptrB_d;
  logic [MAX_COUNT_W-1:0] count_q, count_d;
  logic [MAX_COUNT_W-1:0] issued_q, issued_d;
  logic [31:0]            dataA_q, dataA_d;
  logic [31:0]            dataB_q, dataB_d;
  logic [MAX_COUNT_W:0]   issuedInc;

  // One extra bit so the "more pairs left" compare cannot overflow at max count.
  assign issuedInc = {1'b0, issued_q} + {{MAX_COUNT_W{1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ptrA_q   <= '0;
      ptrB_q   <= '0;
      count_q  <= '0;
      issued_q <= '0;
      dataA_q  <= '0;
      dataB_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptrA_q   <= ptrA_d;
      ptrB_q   <= ptrB_d;
      count_q  <= count_d;
      issued_q <= issued_d;
      dataA_q  <= dataA_d;
      dataB_q  <= dataB_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptrA_d      = ptrA_q;
    ptrB_d      = ptrB_q;
    count_d     = count_q;
    issued_d    = issued_q;
    dataA_d     = dataA_q;
    dataB_d     = dataB_q;
    avm_read    = 1'b0;
    avm_address = '0;
    add_start   = 1'b0;
    add_n       = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (go) begin
          ptrA_d   = base_a;
          ptrB_d   = base_b;
          count_d  = count;
          issued_d = '0;
          state_d  = ST_CLR;
        end
      end
      ST_CLR: begin
        add_start = 1'b1;
        add_n     = N_RESET;
        if (add_done) begin
          state_d = (count_q != '0) ? ST_RD_A : ST_FIN;
        end
      end
      ST_RD_A: begin
        avm_read    = 1'b1;
        avm_address = ptrA_q;
        if (!avm_waitrequest) begin
          state_d = ST_WAIT_A;
        end
      end
      // Read data is only accepted here, so stray or aborted returns are dropped.
      ST_WAIT_A: begin
        if (avm_readdatavalid) begin
          dataA_d = avm_readdata;
          state_d = ST_RD_B;
        end
      end
      ST_RD_B: begin
        avm_read    = 1'b1;
        avm_address = ptrB_q;
        if (!avm_waitrequest) begin
          state_d = ST_WAIT_B;
        end
      end
      ST_WAIT_B: begin
        if (avm_readdatavalid) begin
          dataB_d = avm_readdata;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        add_start = 1'b1;
        add_n     = N_NEXT;
        if (add_done) begin
          issued_d = issuedInc[MAX_COUNT_W-1:0];
          ptrA_d   = ptrA_q + WORD_STRIDE;
          ptrB_d   = ptrB_q + WORD_STRIDE;
          state_d  = (issuedInc < {1'b0, count_q}) ? ST_RD_A : ST_FIN;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy      = (state_q != ST_IDLE);
  assign job_done  = (state_q == ST_FIN);
  assign issued    = issued_q;
  assign add_dataa = dataA_q;
  assign add_datab = dataB_q;

endmodule

// File: tb/tb_matrix_add_feeder.sv
// Directed bench for matrix_add_feeder with a latency-configurable memory
// model and an add engine that can optionally stall its done handshake.
module tb_matrix_add_feeder;

  localparam int N_OFF = 16;
  localparam int CW    = 16;
  localparam logic [31:0] N_NEXT_EXP  = 32'd16;
  localparam logic [31:0] N_RESET_EXP = 32'd18;

  logic          clk = 1'b0;
  logic          reset;
  logic          go;
  logic [31:0]   base_a, base_b;
  logic [CW-1:0] count;
  logic          busy, job_done;
  logic [CW-1:0] issued;
  logic [31:0]   avm_address;
  logic          avm_read;
  logic          avm_waitrequest;
  logic [31:0]   avm_readdata;
  logic          avm_readdatavalid;
  logic          add_start;
  logic [7:0]    add_n;
  logic [31:0]   add_dataa, add_datab;
  logic          add_done;

  logic engineSlow  = 1'b0;
  logic engineReady = 1'b1;
  int   memLatency  = 1;

  int compareCount  = 0;
  int mismatchCount = 0;
  int doneCount     = 0;

  logic [31:0] readLog[$];
  logic [31:0] issN[$];
  logic [31:0] issA[$];
  logic [31:0] issB[$];

  matrix_add_feeder #(.N_OFFSET(N_OFF), .MAX_COUNT_W(CW)) dut (
    .clk(clk), .reset(reset), .go(go),
    .base_a(base_a), .base_b(base_b), .count(count),
    .busy(busy), .job_done(job_done), .issued(issued),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .add_start(add_start), .add_n(add_n),
    .add_dataa(add_dataa), .add_datab(add_datab), .add_done(add_done)
  );

  always #5 clk = ~clk;

  assign add_done = add_start && engineReady;

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return addr ^ 32'h5A5A_0F0F;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Pulse go for one cycle; returns #1 after the edge that sampled it.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic [CW-1:0] cnt);
    @(posedge clk); #1;
    base_a = a; base_b = b; count = cnt; go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
  endtask

  task automatic waitJobDone(input string tag, input int maxCycles);
    bit seen = 1'b0;
    for (int i = 0; i < maxCycles && !seen; i++) begin
      @(negedge clk);
      seen = job_done;
    end
    if (!seen) checkOutput({tag, "_done_timeout"}, 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic verifyPairs(input string tag, input int r0, input int i0,
                             input logic [31:0] a0, input logic [31:0] b0,
                             input int pairs);
    logic [31:0] ea, eb;
    checkOutput({tag, "_reads"}, 32'(readLog.size() - r0), 32'(2 * pairs));
    checkOutput({tag, "_issues"}, 32'(issN.size() - i0), 32'(pairs + 1));
    if (issN.size() > i0) checkOutput({tag, "_reset_op"}, issN[i0], N_RESET_EXP);
    for (int k = 0; k < pairs; k++) begin
      ea = a0 + 32'(4 * k);
      eb = b0 + 32'(4 * k);
      if (readLog.size() >= r0 + 2 * k + 2) begin
        checkOutput($sformatf("%s_rdA%0d", tag, k), readLog[r0 + 2 * k], ea);
        checkOutput($sformatf("%s_rdB%0d", tag, k), readLog[r0 + 2 * k + 1], eb);
      end
      if (issN.size() >= i0 + k + 2) begin
        checkOutput($sformatf("%s_op%0d", tag, k), issN[i0 + k + 1], N_NEXT_EXP);
        checkOutput($sformatf("%s_da%0d", tag, k), issA[i0 + k + 1], memWord(ea));
        checkOutput($sformatf("%s_db%0d", tag, k), issB[i0 + k + 1], memWord(eb));
      end
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_job_done"}, 32'(job_done), 32'd0);
    checkOutput({tag, "_issued"}, 32'(issued), 32'd0);
    checkOutput({tag, "_avm_address"}, avm_address, 32'd0);
    checkOutput({tag, "_avm_read"}, 32'(avm_read), 32'd0);
    checkOutput({tag, "_add_start"}, 32'(add_start), 32'd0);
    checkOutput({tag, "_add_n"}, 32'(add_n), 32'd0);
    checkOutput({tag, "_add_dataa"}, add_dataa, 32'd0);
    checkOutput({tag, "_add_datab"}, add_datab, 32'd0);
  endtask

  // Memory: accepts a read at the negedge it is visible without waitrequest,
  // returns data memLatency cycles after the accepting edge.
  initial begin
    logic [31:0] addr;
    avm_readdatavalid = 1'b0;
    avm_readdata      = '0;
    forever begin
      @(negedge clk);
      if (avm_read && !avm_waitrequest) begin
        addr = avm_address;
        repeat (memLatency) @(posedge clk);
        #1;
        avm_readdatavalid = 1'b1;
        avm_readdata      = memWord(addr);
        @(posedge clk); #1;
        avm_readdatavalid = 1'b0;
        avm_readdata      = '0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      engineReady = engineSlow ? ~engineReady : 1'b1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (avm_read && !avm_waitrequest) readLog.push_back(avm_address);
      if (add_start && add_done) begin
        issN.push_back(32'(add_n));
        issA.push_back(add_dataa);
        issB.push_back(add_datab);
      end
      if (job_done) doneCount++;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int r0, i0, d0;
    bit seen;
    reset = 1'b1; go = 1'b0; base_a = '0; base_b = '0; count = '0;
    avm_waitrequest = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    reset = 1'b0;

    // Three pairs, zero-wait memory
    r0 = readLog.size(); i0 = issN.size(); d0 = doneCount;
    applyStimulus(32'h100, 32'h200, 16'd3);
    waitJobDone("basic", 100);
    verifyPairs("basic", r0, i0, 32'h100, 32'h200, 3);
    checkOutput("basic_issued", 32'(issued), 32'd3);
    checkOutput("basic_done_count", 32'(doneCount - d0), 32'd1);
    checkOutput("basic_busy_after", 32'(busy), 32'd0);

    // Empty job: RESET only, job_done two cycles after go
    r0 = readLog.size(); i0 = issN.size();
    applyStimulus(32'h1000, 32'h2000, 16'd0);
    checkOutput("zero_clr_start", 32'(add_start), 32'd1);
    checkOutput("zero_clr_n", 32'(add_n), N_RESET_EXP);
    checkOutput("zero_clr_done", 32'(job_done), 32'd0);
    @(posedge clk); #1;
    checkOutput("zero_fin_done", 32'(job_done), 32'd1);
    checkOutput("zero_fin_start", 32'(add_start), 32'd0);
    @(posedge clk); #1;
    checkOutput("zero_idle_busy", 32'(busy), 32'd0);
    checkOutput("zero_reads", 32'(readLog.size() - r0), 32'd0);
    checkOutput("zero_issues", 32'(issN.size() - i0), 32'd1);
    checkOutput("zero_issued", 32'(issued), 32'd0);

    // Waitrequest held for 4 cycles on the first read
    r0 = readLog.size(); i0 = issN.size();
    avm_waitrequest = 1'b1;
    applyStimulus(32'h40, 32'h80, 16'd1);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("wait_read%0d", c), 32'(avm_read), 32'd1);
      checkOutput($sformatf("wait_addr%0d", c), avm_address, 32'h40);
    end
    avm_waitrequest = 1'b0;
    waitJobDone("wait", 100);
    verifyPairs("wait", r0, i0, 32'h40, 32'h80, 1);

    // Address wrap with a stalling add engine
    r0 = readLog.size(); i0 = issN.size();
    engineSlow = 1'b1;
    applyStimulus(32'hFFFF_FFFC, 32'h10, 16'd2);
    waitJobDone("wrap", 100);
    engineSlow = 1'b0;
    verifyPairs("wrap", r0, i0, 32'hFFFF_FFFC, 32'h10, 2);
    if (readLog.size() >= r0 + 3) checkOutput("wrap_second_a", readLog[r0 + 2], 32'h0000_0000);

    // Reset in WAIT_B of pair 2 with slow memory; late data must be dropped
    r0 = readLog.size();
    memLatency = 3;
    applyStimulus(32'h700, 32'h800, 16'd3);
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      seen = (readLog.size() >= r0 + 4);
    end
    if (!seen) checkOutput("abort_reach_waitb", 32'd0, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checkAllZero("abort_now");
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkAllZero("abort_late");
    memLatency = 1;
    r0 = readLog.size(); i0 = issN.size(); d0 = doneCount;
    applyStimulus(32'h300, 32'h400, 16'd1);
    waitJobDone("restart", 100);
    verifyPairs("restart", r0, i0, 32'h300, 32'h400, 1);
    checkOutput("restart_issued", 32'(issued), 32'd1);
    checkOutput("restart_done_count", 32'(doneCount - d0), 32'd1);

    // go while busy is ignored
    r0 = readLog.size(); i0 = issN.size(); d0 = doneCount;
    applyStimulus(32'h500, 32'h600, 16'd2);
    repeat (2) @(posedge clk);
    #1;
    go = 1'b1; base_a = 32'h900; base_b = 32'hA00; count = 16'd5;
    @(posedge clk); #1;
    go = 1'b0;
    waitJobDone("busygo", 100);
    repeat (10) @(posedge clk);
    #1;
    verifyPairs("busygo", r0, i0, 32'h500, 32'h600, 2);
    checkOutput("busygo_issued", 32'(issued), 32'd2);
    checkOutput("busygo_done_count", 32'(doneCount - d0), 32'd1);
    checkOutput("busygo_idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
